// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and helpers for the Viterbi survivor/traceback path
package viterbi_pkg;

    // Traceback controller phases
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_TRACE  = 2'd1,
        ST_EMIT   = 2'd2
    } tb_state_e;

    // Ceiling log2 usable in constant expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Predecessor of state s given its decision bit d: {d, s[sw-1:1]}
    function automatic int unsigned pred_state(input int unsigned s, input logic d,
                                               input int unsigned sw);
        return (s >> 1) | ({31'd0, d} << (sw - 1));
    endfunction

endpackage

// File: rtl/survivor_ram.sv
// rtl/survivor_ram.sv - circular survivor memory, sync write / async read
module survivor_ram #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store one decision vector per accepted trellis step
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/viterbi_traceback_unit.sv
// rtl/viterbi_traceback_unit.sv - sliding-window survivor traceback with chronological bit output
module viterbi_traceback_unit
    import viterbi_pkg::*;
#(
    parameter int K          = 3,
    parameter int TB_DEPTH   = 15,
    parameter int DEC_LEN    = 1,
    parameter int TERMINATED = 0,
    localparam int NS        = 2 ** (K - 1),
    localparam int SW        = K - 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [NS-1:0] dec_vec,
    input  logic [SW-1:0] best_state,
    output logic          dx,
    output logic          dx_valid,
    output logic          busy
);

    localparam int MEM = TB_DEPTH + DEC_LEN;
    localparam int AW  = clog2(MEM);
    localparam int CW  = clog2(MEM + 1);
    localparam int EW  = clog2(DEC_LEN + 1);

    tb_state_e          r_state;
    logic               r_dec_ready;
    logic               r_dx;
    logic               r_dx_valid;
    logic               r_busy;
    logic               r_first;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_tptr;
    logic [CW-1:0]      r_fill;
    logic [CW-1:0]      r_step;
    logic [EW-1:0]      r_ecnt;
    logic [SW-1:0]      r_cur;
    logic [DEC_LEN-1:0] r_lifo;

    logic               w_xfer;
    logic [NS-1:0]      w_rd_vec;
    logic               w_dbit;
    logic [SW-1:0]      w_next;
    logic [CW-1:0]      w_need;
    logic [AW-1:0]      w_wptr_nxt;
    logic [AW-1:0]      w_tptr_nxt;

    assign w_xfer     = dec_valid & r_dec_ready;
    assign w_dbit     = w_rd_vec[r_cur];
    assign w_next     = SW'(pred_state(32'(r_cur), w_dbit, 32'(SW)));
    // First window must fill the whole memory; later windows only slide by DEC_LEN
    assign w_need     = r_first ? CW'(MEM) : CW'(DEC_LEN);
    assign w_wptr_nxt = (r_wptr == AW'(MEM - 1)) ? '0 : r_wptr + 1'b1;
    assign w_tptr_nxt = (r_tptr == '0) ? AW'(MEM - 1) : r_tptr - 1'b1;

    survivor_ram #(
        .DEPTH (MEM),
        .WIDTH (NS),
        .AW    (AW)
    ) u_survivor_ram (
        .i_clk   (clock),
        .i_we    (w_xfer),
        .i_waddr (r_wptr),
        .i_wdata (dec_vec),
        .i_raddr (r_tptr),
        .o_rdata (w_rd_vec)
    );

    // Accept / trace / emit controller with registered handshake and output strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCEPT;
            r_dec_ready <= 1'b0;
            r_dx        <= 1'b0;
            r_dx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_first     <= 1'b1;
            r_wptr      <= '0;
            r_tptr      <= '0;
            r_fill      <= '0;
            r_step      <= '0;
            r_ecnt      <= '0;
            r_cur       <= '0;
            r_lifo      <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    r_dec_ready <= 1'b1;
                    if (w_xfer) begin
                        r_wptr <= w_wptr_nxt;
                        if (r_fill + 1'b1 == w_need) begin
                            r_state     <= ST_TRACE;
                            r_dec_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_fill      <= '0;
                            r_first     <= 1'b0;
                            r_step      <= '0;
                            // Trace starts at the slot just written
                            r_tptr      <= r_wptr;
                            r_cur       <= (TERMINATED != 0) ? '0 : best_state;
                        end else begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                end
                ST_TRACE: begin
                    r_cur  <= w_next;
                    r_tptr <= w_tptr_nxt;
                    r_step <= r_step + 1'b1;
                    if (r_step == CW'(MEM - 1)) begin
                        // Oldest decoded bit goes straight to the output register
                        r_state    <= ST_EMIT;
                        r_dx       <= r_cur[0];
                        r_dx_valid <= 1'b1;
                        r_ecnt     <= '0;
                    end else if (r_step >= CW'(TB_DEPTH)) begin
                        r_lifo <= (r_lifo << 1) | DEC_LEN'(r_cur[0]);
                    end
                end
                ST_EMIT: begin
                    if (r_ecnt == EW'(DEC_LEN - 1)) begin
                        r_dx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_ACCEPT;
                    end else begin
                        r_dx   <= r_lifo[0];
                        r_lifo <= r_lifo >> 1;
                        r_ecnt <= r_ecnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign dec_ready = r_dec_ready;
    assign dx        = r_dx;
    assign dx_valid  = r_dx_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// tb/tb_viterbi_traceback_unit.sv - scoreboard bench for viterbi_traceback_unit
module tb_viterbi_traceback_unit;

    localparam int TBD = 4;
    localparam int SW  = 2;
    localparam int P_DL   [3] = '{2, 2, 3};
    localparam int P_TERM [3] = '{0, 1, 0};

    typedef struct {
        int     u;
        bit     b;
        longint cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic [2:0] rst;
    logic [2:0] dec_valid;
    logic [2:0] dec_ready;
    logic [2:0] dx;
    logic [2:0] dx_valid;
    logic [2:0] busy;
    logic [3:0] dec_vec    [3];
    logic [1:0] best_state [3];

    exp_t   exp_q[$];
    int     hist_vec[$];
    int     hist_best[$];
    int     fill_cnt;
    bit     first_win;
    int     win_count;
    longint busy_lo;
    longint busy_hi;
    int     cur_u;
    bit     last_dx [3];
    longint cyc;
    int     n_vec;
    int     n_err;

    viterbi_traceback_unit #(.K(3), .TB_DEPTH(TBD), .DEC_LEN(2), .TERMINATED(0)) u_dut0 (
        .clock(clock), .reset(rst[0]), .dec_valid(dec_valid[0]), .dec_ready(dec_ready[0]),
        .dec_vec(dec_vec[0]), .best_state(best_state[0]), .dx(dx[0]), .dx_valid(dx_valid[0]),
        .busy(busy[0]));

    viterbi_traceback_unit #(.K(3), .TB_DEPTH(TBD), .DEC_LEN(2), .TERMINATED(1)) u_dut1 (
        .clock(clock), .reset(rst[1]), .dec_valid(dec_valid[1]), .dec_ready(dec_ready[1]),
        .dec_vec(dec_vec[1]), .best_state(best_state[1]), .dx(dx[1]), .dx_valid(dx_valid[1]),
        .busy(busy[1]));

    viterbi_traceback_unit #(.K(3), .TB_DEPTH(TBD), .DEC_LEN(3), .TERMINATED(0)) u_dut2 (
        .clock(clock), .reset(rst[2]), .dec_valid(dec_valid[2]), .dec_ready(dec_ready[2]),
        .dec_vec(dec_vec[2]), .best_state(best_state[2]), .dx(dx[2]), .dx_valid(dx_valid[2]),
        .busy(busy[2]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        hist_vec.delete();
        hist_best.delete();
        fill_cnt  = 0;
        first_win = 1'b1;
        busy_lo   = -100;
        busy_hi   = -100;
        last_dx[cur_u] = 1'b0;
    endtask

    // Walk the survivor path backwards over absolute step indices, then report oldest first
    task automatic model_window();
        int dl, mem, n, s, d;
        int got [8];
        dl  = P_DL[cur_u];
        mem = TBD + dl;
        n   = hist_vec.size();
        s   = (P_TERM[cur_u] != 0) ? 0 : hist_best[n - 1];
        for (int j = 0; j < mem; j++) begin
            if (j >= TBD) got[j - TBD] = s % 2;
            d = (hist_vec[n - 1 - j] >> s) & 1;
            s = (s / 2) + d * (1 << (SW - 1));
        end
        for (int k = 0; k < dl; k++) begin
            exp_t e;
            e.u   = cur_u;
            e.b   = got[dl - 1 - k] != 0;
            e.cyc = cyc + mem + k;
            exp_q.push_back(e);
        end
        busy_lo = cyc;
        busy_hi = cyc + mem + dl - 1;
    endtask

    task automatic model_accept(input int vec, input int best);
        int need;
        hist_vec.push_back(vec);
        hist_best.push_back(best);
        fill_cnt++;
        need = first_win ? (TBD + P_DL[cur_u]) : P_DL[cur_u];
        if (fill_cnt == need) begin
            model_window();
            fill_cnt  = 0;
            first_win = 1'b0;
            win_count++;
        end
    endtask

    // One cycle of stimulus; called on a falling edge, returns on the next one
    task automatic step(input int u, input int mode);
        bit rdy, v;
        int vec, best;
        rdy  = dec_ready[u];
        v    = 1'b1;
        vec  = $urandom_range(0, 15);
        best = $urandom_range(0, 3);
        case (mode)
            0: v = ($urandom_range(0, 3) != 0);
            1: begin vec = 15; best = 3; end
            2: begin vec = 0;  best = 1; end
            3: begin vec = 0;  best = 3; end
            default: ;
        endcase
        dec_valid[u]  = v;
        dec_vec[u]    = 4'(vec);
        best_state[u] = 2'(best);
        @(negedge clock);
        if (v && rdy) model_accept(vec, best);
    endtask

    task automatic run_windows(input int u, input int mode, input int nwin);
        int target;
        target = win_count + nwin;
        for (int i = 0; i < 3000 && win_count < target; i++) step(u, mode);
        check($sformatf("u%0d windows_completed", u), win_count, target);
    endtask

    task automatic check_reset_outputs(input int u);
        check($sformatf("u%0d reset dec_ready", u), dec_ready[u], 0);
        check($sformatf("u%0d reset dx", u), dx[u], 0);
        check($sformatf("u%0d reset dx_valid", u), dx_valid[u], 0);
        check($sformatf("u%0d reset busy", u), busy[u], 0);
    endtask

    task automatic do_reset(input int u);
        cur_u        = u;
        rst[u]       = 1'b1;
        dec_valid[u] = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        check_reset_outputs(u);
        rst[u] = 1'b0;
        check($sformatf("u%0d ready_before_first_edge", u), dec_ready[u], 0);
        @(negedge clock);
        check($sformatf("u%0d ready_after_first_edge", u), dec_ready[u], 1);
    endtask

    // Abort a window during its third traceback cycle; dec_valid stays high throughout
    task automatic trace_reset(input int u);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst[u] = 1'b1;
        model_clear();
        @(negedge clock);
        check_reset_outputs(u);
        rst[u] = 1'b0;
        check($sformatf("u%0d ready_after_abort", u), dec_ready[u], 0);
    endtask

    task automatic finish_dut(input int u);
        dec_valid[u] = 1'b0;
        repeat (20) @(negedge clock);
        check($sformatf("u%0d outstanding_outputs", u), exp_q.size(), 0);
    endtask

    // Scoreboard monitor: pops an expected bit whenever a unit strobes dx_valid
    always @(negedge clock) begin
        #1;
        for (int u = 0; u < 3; u++) begin
            if (dx_valid[u]) begin
                if (exp_q.size() == 0 || exp_q[0].u != u) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL u%0d unexpected_dx_valid: got 1, required 0 (cycle %0d)", u, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("u%0d dx", u), dx[u], e.b);
                    check($sformatf("u%0d dx_cycle", u), cyc, e.cyc);
                    last_dx[u] = e.b;
                end
            end else begin
                check($sformatf("u%0d dx_hold", u), dx[u], last_dx[u]);
                if (exp_q.size() > 0 && exp_q[0].u == u && exp_q[0].cyc <= cyc) begin
                    void'(exp_q.pop_front());
                    n_vec++;
                    n_err++;
                    $display("FAIL u%0d missing_dx_valid: got 0, required 1 (cycle %0d)", u, cyc);
                end
            end
            if (u == cur_u) begin
                check($sformatf("u%0d busy", u), busy[u], (cyc >= busy_lo && cyc <= busy_hi));
                if (cyc >= busy_lo && cyc <= busy_hi + 1)
                    check($sformatf("u%0d dec_ready_while_busy", u), dec_ready[u], 0);
            end
        end
    end

    initial begin
        cyc       = 0;
        n_vec     = 0;
        n_err     = 0;
        win_count = 0;
        cur_u     = 0;
        rst       = 3'b111;
        dec_valid = 3'b000;
        for (int u = 0; u < 3; u++) begin
            dec_vec[u]    = '0;
            best_state[u] = '0;
            last_dx[u]    = 1'b0;
        end
        busy_lo   = -100;
        busy_hi   = -100;
        fill_cnt  = 0;
        first_win = 1'b1;
        @(negedge clock);

        do_reset(0);
        run_windows(0, 1, 5);
        run_windows(0, 2, 3);
        run_windows(0, 0, 20);
        run_windows(0, 4, 1);
        trace_reset(0);
        run_windows(0, 4, 4);
        run_windows(0, 0, 6);
        finish_dut(0);

        do_reset(1);
        run_windows(1, 3, 3);
        run_windows(1, 0, 10);
        finish_dut(1);

        do_reset(2);
        run_windows(2, 4, 3);
        run_windows(2, 0, 12);
        run_windows(2, 2, 3);
        finish_dut(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/viterbi_traceback_unit.md
Name: viterbi_traceback_unit

Overview:
Parametrised survivor-memory and traceback stage for rate-1/n Viterbi decoders of constraint length K. It is the successor to the fixed (2,1,3) backward-label traceback. The ACS stage streams one decision vector per trellis step into it. It performs sliding-window traceback over TB_DEPTH+DEC_LEN steps and emits DEC_LEN decoded bits per window in chronological order. It adds a window length above 1, a valid/ready handshake, and a terminated-trellis mode.

Parameters:
K, 3, constraint length; NS = 2^(K-1) states, SW = K-1 state bits (both derived localparams).
TB_DEPTH, 15, traceback (merge) depth T in trellis steps; must be >= 1.
DEC_LEN, 1, decoded bits released per traceback window; must be >= 1.
TERMINATED, 0, 1 = every traceback starts from state 0 instead of best_state.
MEM = TB_DEPTH+DEC_LEN (derived), survivor memory depth; AW = clog2(MEM).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
dec_valid  in  1  decision vector and best_state are valid this cycle.
dec_ready  out  1  unit accepts a decision this cycle; transfer = dec_valid & dec_ready.
dec_vec  in  NS  decision bit d[s] per state s: predecessor of s is {d[s], s[SW-1:1]}.
best_state  in  SW  minimum-metric state for this step; ignored when TERMINATED=1.
dx  out  1  decoded bit.
dx_valid  out  1  dx is valid this cycle; one-cycle strobe, no backpressure.
busy  out  1  high in TRACE or EMIT.

Behaviour:
- State convention: next state = {s[SW-2:0], u}; the decoded bit at a step is s[0] of the state on the survivor path.
- Reset values: dec_ready=0, dx=0, dx_valid=0, busy=0; write pointer, fill count, trace pointer, LIFO and FSM all cleared. Memory contents are don't-care. The FSM enters ACCEPT, so dec_ready=1 from the first clock edge after reset deasserts.
- FSM states: ACCEPT, TRACE, EMIT.
- ACCEPT:
  - dec_ready=1. Each transfer writes dec_vec into a circular memory at wptr, increments wptr modulo MEM (wraps MEM-1 -> 0), and registers best_state.
  - The required count is MEM for the first window after reset, then DEC_LEN per window.
  - On the transfer that completes the count, the FSM moves to TRACE on the next edge. dec_ready drops in that same next cycle.
- TRACE:
  - cur_state loads best_state of the last transfer, or 0 if TERMINATED. tptr = wptr-1 modulo MEM.
  - One step per clock: cur_state <= {mem[tptr][cur_state], cur_state[SW-1:1]}; tptr decrements modulo MEM.
  - Steps 0..TB_DEPTH-1 discard bits. Steps TB_DEPTH..MEM-1 push cur_state[0] into a DEC_LEN-deep LIFO, taken before the state update.
  - Duration: exactly MEM cycles; then EMIT.
- EMIT: pops the LIFO one bit per cycle with dx_valid=1 for DEC_LEN consecutive cycles. Output is oldest step first. After the last bit the FSM returns to ACCEPT.
- Window latency: the last accepted transfer is followed by MEM+1 cycles to the first dx_valid. Steady-state throughput is DEC_LEN bits per (DEC_LEN + MEM + DEC_LEN + 1) cycles.
- dec_valid while dec_ready=0 has no effect; the upstream holds its data.
- reset asserted mid-TRACE or mid-EMIT aborts immediately (asynchronously). No partial window is emitted after release.
- dx holds its last value when dx_valid=0.

Decomposition:
- Package viterbi_pkg: clog2 function, FSM state encoding (ACCEPT/TRACE/EMIT), and the predecessor-state function shared with the ACS block.
- One natural sub-module: survivor_ram (MEM x NS, one synchronous-write port, one asynchronous-read port indexed by tptr).
- The LIFO and FSM stay in the top module.

Test Plan:
All scenarios use K=3, TB_DEPTH=4, DEC_LEN=2, TERMINATED=0 (MEM=6) unless stated.
- Reset release -> dec_ready=1 on the first edge after release; dx_valid stays 0 through 6 transfers. After the 6th transfer: 6 TRACE cycles, then dx_valid high for exactly 2 cycles; dec_ready low throughout.
- dec_vec=4'b1111, best_state=2'b11 for every step -> every trace stays in state 3; dx=1,1 per window for 5 consecutive windows, crossing wptr wrap.
- dec_vec=4'b0000, best_state=2'b01 on every step -> path 1 then state 0 onward; discarded region absorbs the 1; dx=0,0 per window.
- Same stimulus as the previous scenario with TERMINATED=1 and best_state=2'b11 -> dx=0,0 (best_state ignored).
- Chronological order: a step-indexed decision pattern with a known survivor ending in bits ...1,0 -> dx emitted 1 then 0; DEC_LEN=3 variant emits 3 bits in order.
- Reset pulsed during the 3rd TRACE cycle -> dx_valid never asserts for that window. Refill requires 6 transfers again, and dec_valid held high during TRACE/EMIT is not consumed.
